pwm_src: RTL and testbench



---
 rtl/pwm_src.sv | 154 +++++++++++++++
 tb/tb_pwm_src.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_src.sv
// Programmable PWM source with double-buffered period/high configuration.
// Optional macro PWM_SRC_CYCLE_CNT_EN builds the completed-period counter on cycle_cnt.
module pwm_src #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned DEF_PERIOD = 200,
    parameter int unsigned DEF_HIGH   = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_load,
    output logic             sig_out,
    output logic             high_pulse,
    output logic             low_pulse,
    output logic             period_done,
    output logic             busy,
    output logic [31:0]      cycle_cnt
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   per_a_q, per_a_d;
    logic [CNT_W-1:0]   high_a_q, high_a_d;
    logic [CNT_W-1:0]   per_p_q, per_p_d;
    logic [CNT_W-1:0]   high_p_q, high_p_d;
    logic               pend_valid_q, pend_valid_d;
    logic               sig_q, sig_d;
    logic               high_pulse_q, high_pulse_d;
    logic               low_pulse_q, low_pulse_d;

    logic [CNT_W-1:0]   cfg_per_c, cfg_high_c, pend_per_c, pend_high_c;
    logic               last_cyc;

    // Clamp is applied only on the way into the active registers.
    always_comb begin
        cfg_per_c   = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
        cfg_high_c  = (cfg_high > cfg_per_c) ? cfg_per_c : cfg_high;
        pend_per_c  = (per_p_q < CNT_W'(2)) ? CNT_W'(2) : per_p_q;
        pend_high_c = (high_p_q > pend_per_c) ? pend_per_c : high_p_q;
        last_cyc    = (cnt_q == per_a_q - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            per_a_q      <= CNT_W'(DEF_PERIOD);
            high_a_q     <= CNT_W'(DEF_HIGH);
            per_p_q      <= CNT_W'(DEF_PERIOD);
            high_p_q     <= CNT_W'(DEF_HIGH);
            pend_valid_q <= 1'b0;
            sig_q        <= 1'b0;
            high_pulse_q <= 1'b0;
            low_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            per_a_q      <= per_a_d;
            high_a_q     <= high_a_d;
            per_p_q      <= per_p_d;
            high_p_q     <= high_p_d;
            pend_valid_q <= pend_valid_d;
            sig_q        <= sig_d;
            high_pulse_q <= high_pulse_d;
            low_pulse_q  <= low_pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (last_cyc && !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        per_a_d      = per_a_q;
        high_a_d     = high_a_q;
        per_p_d      = per_p_q;
        high_p_d     = high_p_q;
        pend_valid_d = pend_valid_q;
        sig_d        = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cfg_load) begin
                    per_a_d      = cfg_per_c;
                    high_a_d     = cfg_high_c;
                    pend_valid_d = 1'b0;
                end
                if (en) sig_d = (high_a_d != '0);
            end
            RUN: begin
                if (last_cyc) begin
                    cnt_d = '0;
                    // A same-cycle load wins over anything already pending.
                    if (cfg_load) begin
                        per_a_d      = cfg_per_c;
                        high_a_d     = cfg_high_c;
                        pend_valid_d = 1'b0;
                    end else if (pend_valid_q) begin
                        per_a_d      = pend_per_c;
                        high_a_d     = pend_high_c;
                        pend_valid_d = 1'b0;
                    end
                    sig_d = en && (high_a_d != '0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    sig_d = (cnt_d < high_a_q);
                    if (cfg_load) begin
                        per_p_d      = cfg_period;
                        high_p_d     = cfg_high;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            default: cnt_d = '0;
        endcase
        high_pulse_d = sig_d & ~sig_q;
        low_pulse_d  = ~sig_d & sig_q;
    end

    assign sig_out     = sig_q;
    assign high_pulse  = high_pulse_q;
    assign low_pulse   = low_pulse_q;
    assign busy        = (state_q == RUN);
    assign period_done = (state_q == RUN) && last_cyc;

`ifdef PWM_SRC_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (state_q == RUN && last_cyc) cyc_d = cyc_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign cycle_cnt = cyc_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_pwm_src.sv
// Self-checking bench for pwm_src: phase-position reference model plus directed literal checks.
module tb_pwm_src;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] cfg_period = '0;
    logic [31:0] cfg_high = '0;
    logic        cfg_load = 1'b0;
    logic        sig_out, high_pulse, low_pulse, period_done, busy;
    logic [31:0] cycle_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    pwm_src #(.CNT_W(32), .DEF_PERIOD(200), .DEF_HIGH(100)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_load(cfg_load),
        .sig_out(sig_out), .high_pulse(high_pulse), .low_pulse(low_pulse),
        .period_done(period_done), .busy(busy), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a running flag, a position within the period and the active shape.
    bit          m_run, m_sig, m_prev;
    int unsigned m_pos, m_per, m_hi, p_per, p_hi;
    bit          p_valid;
    logic [31:0] m_cyc;

    function automatic int unsigned clamp_p(input int unsigned p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic int unsigned clamp_h(input int unsigned h, input int unsigned p);
        return (h > p) ? p : h;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 0; m_sig = 0; m_prev = 0; m_pos = 0;
            m_per = 200; m_hi = 100; p_per = 200; p_hi = 100; p_valid = 0; m_cyc = '0;
        end else begin
            m_prev = m_sig;
            if (!m_run) begin
                if (cfg_load) begin
                    m_per = clamp_p(cfg_period);
                    m_hi = clamp_h(cfg_high, m_per);
                    p_valid = 0;
                end
                if (en) begin
                    m_run = 1;
                    m_pos = 0;
                end
            end else if (m_pos == m_per - 1) begin
                m_cyc = m_cyc + 32'd1;
                if (cfg_load) begin
                    m_per = clamp_p(cfg_period);
                    m_hi = clamp_h(cfg_high, m_per);
                end else if (p_valid) begin
                    m_per = clamp_p(p_per);
                    m_hi = clamp_h(p_hi, m_per);
                end
                p_valid = 0;
                m_pos = 0;
                if (!en) m_run = 0;
            end else begin
                if (cfg_load) begin
                    p_per = cfg_period;
                    p_hi = cfg_high;
                    p_valid = 1;
                end
                m_pos++;
            end
            m_sig = m_run && (m_pos < m_hi);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sig_out", {31'd0, sig_out}, {31'd0, m_sig});
            chk("high_pulse", {31'd0, high_pulse}, {31'd0, m_sig & ~m_prev});
            chk("low_pulse", {31'd0, low_pulse}, {31'd0, ~m_sig & m_prev});
            chk("period_done", {31'd0, period_done}, {31'd0, m_run && (m_pos == m_per - 1)});
            chk("busy", {31'd0, busy}, {31'd0, m_run});
`ifdef PWM_SRC_CYCLE_CNT_EN
            chk("cycle_cnt", cycle_cnt, m_cyc);
`else
            chk("cycle_cnt", cycle_cnt, 32'd0);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int unsigned p, input int unsigned h);
        cfg_period = p;
        cfg_high = h;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic wait_pd();
        int n = 0;
        @(negedge clk);
        while (period_done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (period_done !== 1'b1) chk("pd_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_win(input int n, output int hi, output int hp, output int lp,
                             output int pd, output bit first, output bit last_pd);
        hi = 0; hp = 0; lp = 0; pd = 0; first = 0; last_pd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) first = sig_out;
            if (i == n - 1) last_pd = period_done;
            hi += int'(sig_out);
            hp += int'(high_pulse);
            lp += int'(low_pulse);
            pd += int'(period_done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, hp, lp, pd;
        bit first, last_pd;
        logic [31:0] exp_cyc;

        @(posedge clk);
        chk_en = 1'b1;
        tick(3);
        chk("rst_sig", {31'd0, sig_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Defaults: 100 high, 100 low, first high one edge after en.
        en = 1'b1;
        count_win(200, hi, hp, lp, pd, first, last_pd);
        chk("def_first_high", {31'd0, first}, 32'd1);
        chk("def_high_cycles", hi, 100);
        chk("def_pd_count", pd, 1);
        chk("def_pd_last", {31'd0, last_pd}, 32'd1);

        // Mid-period reload takes effect only at the boundary.
        tick(51);
        load(10, 3);
        wait_pd();
        count_win(10, hi, hp, lp, pd, first, last_pd);
        chk("p10h3_high", hi, 3);
        chk("p10h3_hpulse", hp, 1);
        chk("p10h3_lpulse", lp, 1);
        chk("p10h3_pd", pd, 1);

        load(10, 0);
        wait_pd();
        count_win(20, hi, hp, lp, pd, first, last_pd);
        chk("h0_high", hi, 0);
        chk("h0_pulses", hp + lp, 0);
        chk("h0_pd", pd, 2);

        load(10, 10);
        wait_pd();
        count_win(20, hi, hp, lp, pd, first, last_pd);
        chk("hfull_high", hi, 20);
        chk("hfull_pulses", hp + lp, 0);
        chk("hfull_pd", pd, 2);

        load(1, 5);
        wait_pd();
        count_win(10, hi, hp, lp, pd, first, last_pd);
        chk("clamp_high", hi, 10);
        chk("clamp_pd", pd, 5);

        // Graceful stop: en dropped at position 4 of a 10-cycle period.
        load(10, 10);
        tick(4);
        en = 1'b0;
        wait_pd();
        chk("stop_busy_at_pd", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_sig", {31'd0, sig_out}, 32'd0);
        chk("stop_lpulse", {31'd0, low_pulse}, 32'd1);

        // Completed-period counter over 25 periods of 4.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        load(4, 2);
        en = 1'b1;
        for (int i = 0; i < 25; i++) wait_pd();
        en = 1'b0;
`ifdef PWM_SRC_CYCLE_CNT_EN
        exp_cyc = 32'd25;
`else
        exp_cyc = 32'd0;
`endif
        @(negedge clk);
        chk("cyc_busy", {31'd0, busy}, 32'd0);
        chk("cyc_count", cycle_cnt, exp_cyc);
        tick(5);
        chk("cyc_hold", cycle_cnt, exp_cyc);

        en = 1'b1;
        tick(7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outs", {26'd0, sig_out, high_pulse, low_pulse, period_done, busy, 1'b0}, 32'd0);
        chk("midrst_cyc", cycle_cnt, 32'd0);
        rst_n = 1'b1;

        // Randomized configuration, enable and reset traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 40) == 0) en = ~en;
            cfg_load = ($urandom_range(0, 12) == 0);
            cfg_period = $urandom_range(0, 12);
            cfg_high = $urandom_range(0, 14);
            rst_n = ($urandom_range(0, 1500) != 0);
            @(negedge clk);
        end
        cfg_load = 1'b0;
        rst_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
